// File: rtl/vd_frame_sched.sv
// vd_frame_sched: frame scheduler for the Viterbi decoder datapath.
// Turns a start request into a full decoder run: decoder reset, paced code
// symbols with upstream stall handling, zero tail and traceback drain, and
// framing of exactly FRAME_LEN decoded info bits.
// Optional feature macro: VD_FRAME_STATS_EN adds frame_cnt / stall_cnt outputs.
module vd_frame_sched #(
  parameter int WD_CODE   = 2,
  parameter int SYM_CYC   = 8,
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 6,
  parameter int DEC_LAT   = 40,
  parameter int RST_CYC   = 2
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WD_CODE-1:0] in_code,
  output logic               DecReset,
  output logic               Active,
  output logic [WD_CODE-1:0] Code,
  input  logic               DecodeOut,
  output logic               out_valid,
  output logic               out_bit,
  output logic               out_last
`ifdef VD_FRAME_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam logic [15:0] LAST_PHASE = 16'(SYM_CYC - 1);
  localparam logic [15:0] LAST_RST   = 16'(RST_CYC - 1);
  // symCnt values seen at the boundary that ends the last data / tail symbol
  localparam logic [15:0] DATA_END   = 16'(FRAME_LEN - 1);
  localparam logic [15:0] TAIL_END   = 16'(FRAME_LEN + TAIL_LEN - 1);
  localparam logic [15:0] TOTAL_SYM  = 16'(FRAME_LEN + TAIL_LEN + DEC_LAT);
  // symCnt window (symCnt = completed index + 1) that carries info bits
  localparam logic [15:0] FIRST_OUT  = 16'(DEC_LAT + 1);
  localparam logic [15:0] LAST_OUT   = 16'(DEC_LAT + FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE,
    DRST,
    DATA,
    TAIL,
    DRAIN,
    DONE
  } stateT;

  stateT              state;
  stateT              nextState;
  logic [15:0]        phase;
  logic [15:0]        symCnt;
  logic [15:0]        rstCnt;
  logic               atBoundary;
  logic               symbolState;
  logic               issue;
  logic               stall;
  logic               sampleEn;
  logic [WD_CODE-1:0] issueCode;

  assign atBoundary  = (phase == LAST_PHASE);
  assign symbolState = state inside {DATA, TAIL, DRAIN};
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  // Ready depends only on state and phase so upstream never sees a comb loop.
  assign in_ready    = (state == DATA) && atBoundary;
  // A symbol period just completed with the decoder running on it.
  assign sampleEn    = symbolState && atBoundary && Active;

  // State register.
  always_ff @(posedge CLOCK) begin
    // NOTE: every sequential assignment is non-blocking so all registers see
    // pre-edge values and simulation matches the synthesized flops.
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode plus per-edge symbol issue / stall decisions.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    nextState = state;
    issue     = 1'b0;
    stall     = 1'b0;
    issueCode = '0;
    unique case (state)
      IDLE:  if (start) nextState = DRST;
      DRST:  if (rstCnt == LAST_RST) nextState = DATA;
      DATA: begin
        if (atBoundary) begin
          if (in_valid) begin
            issue     = 1'b1;
            issueCode = in_code;
            if (symCnt == DATA_END) nextState = (TAIL_LEN == 0) ? DRAIN : TAIL;
          end else begin
            stall = 1'b1;
          end
        end
      end
      TAIL: begin
        if (atBoundary) begin
          issue = 1'b1;
          if (symCnt == TAIL_END) nextState = DRAIN;
        end
      end
      DRAIN: begin
        // The boundary after the last drain symbol only closes it out.
        if (atBoundary) begin
          if (symCnt == TOTAL_SYM) nextState = DONE;
          else                     issue = 1'b1;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: decoder drive, symbol pacing and output bit framing.
  always_ff @(posedge CLOCK) begin
    // NOTE: every output register is reset so a mid-frame reset leaves no
    // stale symbol, strobe or partial frame behind.
    if (Reset) begin
      phase     <= '0;
      symCnt    <= '0;
      rstCnt    <= '0;
      DecReset  <= 1'b1;
      Active    <= 1'b0;
      Code      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      DecReset  <= (nextState == DRST);
      rstCnt    <= (state == DRST) ? rstCnt + 16'd1 : 16'd0;

      // Phase: preset to the boundary so the first symbol is taken at once,
      // restart on issue, saturate at the boundary while waiting.
      if (state == DRST && nextState == DATA) phase <= LAST_PHASE;
      else if (issue)                          phase <= '0;
      else if (symbolState && !atBoundary)     phase <= phase + 16'd1;
      else if (!symbolState)                   phase <= '0;

      if (issue) begin
        Code   <= issueCode;
        Active <= 1'b1;
        symCnt <= symCnt + 16'd1;
      end else if (stall) begin
        Active <= 1'b0;
      end else if (nextState == DONE) begin
        Active <= 1'b0;
        Code   <= '0;
      end else if (state == IDLE || state == DONE) begin
        symCnt <= '0;
      end

      // Only symbols DEC_LAT..DEC_LAT+FRAME_LEN-1 carry info bits.
      if (sampleEn && symCnt >= FIRST_OUT && symCnt <= LAST_OUT) begin
        out_valid <= 1'b1;
        out_bit   <= DecodeOut;
        out_last  <= (symCnt == LAST_OUT);
      end
    end
  end

`ifdef VD_FRAME_STATS_EN
  // Frame and per-frame stall statistics.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
      if (state == IDLE && start)             stall_cnt <= '0;
      else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vd_frame_sched.sv
// tb_vd_frame_sched: directed bench for vd_frame_sched with an out-bit
// scoreboard and a behavioural decoder that delays a bit pattern by DEC_LAT
// symbols. Stats checks are compiled when VD_FRAME_STATS_EN is defined.
module tb_vd_frame_sched;

  localparam int SYM = 4;
  localparam int FRM = 4;
  localparam int TL  = 2;
  localparam int DL  = 3;
  localparam int RC  = 2;

  logic       CLOCK = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = '0;
  logic       DecodeOut = 1'b0;
  logic       busy, done, in_ready, DecReset, Active, out_valid, out_bit, out_last;
  logic [1:0] Code;
`ifdef VD_FRAME_STATS_EN
  logic [15:0] frame_cnt, stall_cnt;
`endif

  vd_frame_sched #(
    .WD_CODE(2), .SYM_CYC(SYM), .FRAME_LEN(FRM), .TAIL_LEN(TL), .DEC_LAT(DL), .RST_CYC(RC)
  ) dut (
    .CLOCK(CLOCK), .Reset(Reset), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .DecReset(DecReset), .Active(Active), .Code(Code), .DecodeOut(DecodeOut),
    .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last)
`ifdef VD_FRAME_STATS_EN
    , .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic b;
    logic last;
  } expT;

  int   checks = 0;
  int   errors = 0;
  int   edgeCnt = 0;
  int   doneCnt = 0;
  int   actCnt = 0;
  expT  sbq[$];
  expT  e;
  logic pattern[4];
  logic [1:0] codes[4];
  int   stallAt = -1;
  int   stallLen = 0;
  bit   pokeStart = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Edge numbering: at a negedge, edgeCnt is the number of the last posedge.
  always @(posedge CLOCK) edgeCnt <= edgeCnt + 1;

  // Decoder model: while Active, symbol k spans SYM active cycles and its
  // last cycle presents pattern[k-DL] for info symbols, 0 otherwise.
  always @(negedge CLOCK) begin
    if (DecReset) actCnt = 0;
    else if (Active) begin
      int k;
      k = actCnt / SYM;
      DecodeOut = (k >= DL && k < DL + FRM) ? pattern[k - DL] : 1'b0;
      actCnt++;
    end
  end

  // Scoreboard monitor for decoded bits.
  always @(negedge CLOCK) begin
    if (out_last && !out_valid) check("out_last_without_valid", out_last, 0);
    if (out_valid) begin
      if (sbq.size() == 0) check("out_valid_unexpected", out_valid, 0);
      else begin
        e = sbq.pop_front();
        check("out_bit", out_bit, e.b);
        check("out_last", out_last, e.last);
      end
    end
  end

  always @(negedge CLOCK) if (done) doneCnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic runFrame(input string tag);
    int hsEdge[4];
    int n;
    int nst;
    int doneBase;
    int extra;
    extra    = (stallAt >= 0) ? stallLen : 0;
    doneBase = doneCnt;
    for (int i = 0; i < FRM; i++) sbq.push_back({pattern[i], 1'(i == FRM - 1)});
    @(negedge CLOCK);
    start = 1'b1; in_valid = 1'b1; in_code = codes[0];
    @(negedge CLOCK);
    start = 1'b0;
    n = 0;
    while (DecReset && n < 10) begin n++; @(negedge CLOCK); end
    check({tag, "_decreset_len"}, n, RC);
    n = 0;
    while (!in_ready && n < 20) begin n++; @(negedge CLOCK); end
    check({tag, "_first_ready"}, in_ready, 1);
    for (int hs = 0; hs < FRM; hs++) begin
      hsEdge[hs] = edgeCnt + 1;
      if (hs > 0)
        check({tag, "_hs_gap"}, hsEdge[hs] - hsEdge[hs-1], SYM + ((hs == stallAt) ? stallLen : 0));
      @(negedge CLOCK);
      check({tag, "_code"}, Code, codes[hs]);
      check({tag, "_active"}, Active, 1);
      if (hs < FRM - 1) begin
        in_code = codes[hs+1];
        if (pokeStart && hs == 1) begin
          start = 1'b1;
          @(negedge CLOCK);
          start = 1'b0;
          check({tag, "_poke_ignored"}, DecReset, 0);
        end
        if (hs + 1 == stallAt) begin
          in_valid = 1'b0;
          n = 0; nst = 0;
          while (n < 40) begin
            @(negedge CLOCK);
            n++;
            if (in_ready) begin
              if (nst == stallLen) break;
              if (nst > 0) check({tag, "_stall_active"}, Active, 0);
              check({tag, "_stall_code"}, Code, codes[hs]);
              nst++;
            end
          end
          check({tag, "_stall_cycles"}, nst, stallLen);
          in_valid = 1'b1;
        end else begin
          n = 0;
          do begin @(negedge CLOCK); n++; end while (!in_ready && n < 20);
          check({tag, "_ready"}, in_ready, 1);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    for (int j = 0; j < TL + DL; j++) begin
      repeat (SYM) @(negedge CLOCK);
      check({tag, "_zero_code"}, Code, 0);
      check({tag, "_zero_active"}, Active, 1);
    end
    n = 0;
    do begin @(negedge CLOCK); n++; end while (!done && n < 20);
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_done_latency"}, edgeCnt - hsEdge[0], (FRM + TL + DL) * SYM + extra);
    check({tag, "_done_active"}, Active, 0);
    @(negedge CLOCK);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    repeat (4) @(negedge CLOCK);
    check({tag, "_done_count"}, doneCnt - doneBase, 1);
    check({tag, "_sb_empty"}, sbq.size(), 0);
  endtask

  task automatic resetMidFrame();
    int n;
    int seen;
    int doneBase;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) sbq.push_back({pattern[i], 1'b0});
    doneBase = doneCnt;
    @(negedge CLOCK);
    start = 1'b1; in_valid = 1'b1; in_code = 2'd1;
    @(negedge CLOCK);
    start = 1'b0;
    n = 0; seen = 0;
    while (seen < 3 && n < 100) begin
      @(negedge CLOCK);
      n++;
      if (out_valid) seen++;
    end
    check("rst_bits_before_drain", seen, 3);
    in_valid = 1'b0;
    @(negedge CLOCK);
    check("rst_in_drain_busy", busy, 1);
    Reset = 1'b1;
    @(negedge CLOCK);
    check("rst_decreset", DecReset, 1);
    check("rst_active", Active, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_code", Code, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    Reset = 1'b0;
    @(negedge CLOCK);
    check("rst_release_decreset", DecReset, 0);
    repeat (40) @(negedge CLOCK);
    check("rst_no_done", doneCnt - doneBase, 0);
    check("rst_sb_empty", sbq.size(), 0);
    check("rst_idle", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK);
    check("reset_decreset", DecReset, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_active", Active, 0);
    check("reset_code", Code, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_bit", out_bit, 0);
    check("reset_out_last", out_last, 0);
    Reset = 1'b0;
    @(negedge CLOCK);
    check("release_decreset", DecReset, 0);

    codes = '{2'd1, 2'd2, 2'd3, 2'd0};
    pattern = '{1'b1, 1'b0, 1'b1, 1'b1};
    runFrame("basic");
`ifdef VD_FRAME_STATS_EN
    check("basic_stall_cnt", stall_cnt, 0);
`endif

    pattern = '{1'b0, 1'b1, 1'b1, 1'b0};
    stallAt = 2; stallLen = 5;
    runFrame("starve");
    stallAt = -1; stallLen = 0;
`ifdef VD_FRAME_STATS_EN
    check("starve_stall_cnt", stall_cnt, 5);
    check("starve_frame_cnt", frame_cnt, 2);
`endif

    codes = '{2'd3, 2'd1, 2'd2, 2'd2};
    pattern = '{1'b1, 1'b1, 1'b0, 1'b1};
    pokeStart = 1'b1;
    runFrame("busy_start");
    pokeStart = 1'b0;

    resetMidFrame();
`ifdef VD_FRAME_STATS_EN
    check("rst_frame_cnt", frame_cnt, 0);
`endif

    codes = '{2'd2, 2'd0, 2'd1, 2'd3};
    pattern = '{1'b0, 1'b0, 1'b1, 1'b1};
    runFrame("clean1");
    pattern = '{1'b1, 1'b1, 1'b1, 1'b0};
    runFrame("clean2");
    pattern = '{1'b0, 1'b1, 1'b0, 1'b1};
    runFrame("clean3");
`ifdef VD_FRAME_STATS_EN
    check("stats_frame_cnt", frame_cnt, 3);
    check("stats_stall_cnt", stall_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vd_frame_sched.md
# vd_frame_sched

Frame scheduler for the Viterbi decoder datapath. It sits between an upstream symbol source and the decoder top level, and turns a start request into a complete decoder run:

- issues the decoder reset;
- paces code symbols into `Code`/`Active` at one symbol per `SYM_CYC` clocks, stalling on upstream starvation;
- appends the encoder tail and the traceback drain as zero symbols;
- samples `DecodeOut` and returns exactly `FRAME_LEN` framed info bits.

## Interface

Parameters:
- `WD_CODE`, 2: code symbol width; matches the decoder `Code` port.
- `SYM_CYC`, 8: CLOCK cycles per decoder symbol (ACS segment sweep). Minimum 2.
- `FRAME_LEN`, 64: info bits per frame. Minimum 1.
- `TAIL_LEN`, 6: zero tail symbols (K-1).
- `DEC_LAT`, 40: decoder latency in symbols, from symbol issue to its decoded bit on `DecodeOut`.
- `RST_CYC`, 2: decoder reset pulse length in cycles. Minimum 1.
- Constraint: `FRAME_LEN+TAIL_LEN+DEC_LAT` ≤ 65535. All counters are 16 bits.

Ports:
- `CLOCK`, in, 1: single clock; everything is rising-edge.
- `Reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin a frame. Sampled only in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at end of frame.
- `in_valid`, in, 1: upstream symbol valid.
- `in_ready`, out, 1: scheduler accepts a symbol this cycle.
- `in_code`, in, `WD_CODE`: upstream symbol.
- `DecReset`, out, 1: decoder reset, active-high, registered.
- `Active`, out, 1: decoder enable, registered.
- `Code`, out, `WD_CODE`: symbol to the decoder. Held stable for the whole symbol period.
- `DecodeOut`, in, 1: decoder output bit.
- `out_valid`, out, 1: one-cycle strobe qualifying `out_bit`. There is no backpressure.
- `out_bit`, out, 1: decoded info bit.
- `out_last`, out, 1: asserted together with `out_valid` on info bit `FRAME_LEN-1`.

## Operation

- States: IDLE → DRST → DATA → TAIL → DRAIN → DONE → IDLE.
- **IDLE**
  - `start`=1 → DRST.
  - `start` in any other state is ignored.
- **DRST**
  - `DecReset`=1 for `RST_CYC` cycles, `Active`=0.
  - On exit, `phase` is preset to `SYM_CYC-1`, the symbol boundary.
- **Symbol phase counter `phase`**
  - Counts 0..`SYM_CYC-1`.
  - Resets to 0 at each symbol issue.
  - Saturates at `SYM_CYC-1` while stalled.
- **DATA**
  - `in_ready` = (`phase`==`SYM_CYC-1`). It is combinational from state and phase, not from `in_valid`.
  - On handshake: `Code`←`in_code`, `Active`←1, `phase`←0, `sym_cnt`++.
  - At the boundary with `in_valid`=0 (stall): `Active`←0, `Code` holds, `phase` holds.
  - After `FRAME_LEN` handshakes → TAIL.
- **TAIL**
  - `in_ready`=0.
  - Issues `TAIL_LEN` zero symbols back-to-back; no stalls.
  - `TAIL_LEN`=0 skips the state.
- **DRAIN**
  - Issues `DEC_LAT` zero symbols, then → DONE.
- **Output sampling**
  - Occurs at every cycle with `phase`==`SYM_CYC-1` and `Active`=1.
  - Completed symbol index k = `sym_cnt`-1.
  - If k ≥ `DEC_LAT` and k-`DEC_LAT` < `FRAME_LEN`: `out_bit`←`DecodeOut`, `out_valid` pulses.
  - `out_last` is set when k-`DEC_LAT` == `FRAME_LEN-1`.
  - Tail and drain bits are discarded.
- **DONE**
  - `Active`←0, `Code`←0, `done`=1 for one cycle → IDLE.
  - `sym_cnt` clears.
- **Reset mid-frame**
  - All outputs return to reset values on the next edge.
  - The partial frame is discarded; no `out_last` and no `done` are produced.

## Timing

- Reset values:
  - `DecReset`=1.
  - `busy`, `done`, `in_ready`, `Active`, `out_valid`, `out_bit`, `out_last` = 0.
  - `Code`=0.
  - After `Reset` falls, `DecReset` drops to 0 on the first edge in IDLE.
- Per-edge latencies:
  - `start` to `DecReset`=1: 1 cycle.
  - Handshake edge to `Code`/`Active` update: same edge.
- `out_valid`/`out_bit`/`out_last` are registered. They are visible in the cycle after the sampling cycle (`phase`==`SYM_CYC-1`).
- Frame duration without stalls: the first handshake at cycle t gives `done` at t+(`FRAME_LEN`+`TAIL_LEN`+`DEC_LAT`)·`SYM_CYC`.
  - Each stall cycle adds exactly 1 cycle.
- Info bit i appears `DEC_LAT`·`SYM_CYC` cycles after symbol i's sample point plus stalls.
- If a stall and the last DATA handshake coincide, the handshake wins; there is no stall on an accepted symbol.

## Configuration

- `VD_FRAME_STATS_EN` defined: adds outputs `frame_cnt` [15:0] and `stall_cnt` [15:0].
  - `frame_cnt`: completed frames, wraps at 65535→0.
  - `stall_cnt`: stall cycles in the current frame, cleared on entry to DRST, saturates at 65535.
  - Both reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan

All scenarios use `SYM_CYC`=4, `FRAME_LEN`=4, `TAIL_LEN`=2, `DEC_LAT`=3, `RST_CYC`=2.

- **Basic frame:** `start` pulse, `in_valid` held 1, symbols 1,2,3,0 → `DecReset` high 2 cycles; exactly 4 `in_ready`/`in_valid` handshakes 4 cycles apart; `Code` sequence 1,2,3,0,0,0,0,0,0; `done` 36 cycles after the first handshake.
- **Output framing:** decoder model with `DecodeOut` = delayed-by-3-symbols bit pattern 1,0,1,1 → exactly 4 `out_valid` pulses with bits 1,0,1,1; `out_last` only on the 4th.
- **Starvation:** `in_valid`=0 for 5 cycles before the 3rd symbol → `Active`=0 during the stall; `Code` holds 2; `done` is delayed by exactly 5 cycles; `stall_cnt`=5 with `VD_FRAME_STATS_EN`.
- **Start while busy:** `start` pulse during DATA → ignored; a single `done`.
- **Mid-frame reset:** `Reset` during DRAIN → next edge `DecReset`=1, `Active`=0, `busy`=0; no `done`, no further `out_valid`; a new `start` runs a clean full frame.
- **Stats:** 3 back-to-back frames with `VD_FRAME_STATS_EN` → `frame_cnt`=3.
